// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: default data width, the state
// encoding of the TX scheduler FSM and the width of its inter-frame gap counter.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int GAP_CNT_W       = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ      = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

endpackage

// File: rtl/uart_tx_sched.sv
// TX scheduler: pops one byte from the TX FIFO, hands it to the transmitter and
// waits out the frame plus an optional idle gap. Macro UART_TX_SCHED_CTS_EN adds cts_n.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
`ifdef UART_TX_SCHED_CTS_EN
  input  logic                  cts_n,
`endif
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  active,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  logic [2:0]            state_q, state_d;
  logic [GAP_CNT_W-1:0]  gap_q, gap_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic                  rd_en_q, start_q, active_q;
  logic                  cts_ok;

`ifdef UART_TX_SCHED_CTS_EN
  assign cts_ok = ~cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE:     if (en && !fifo_empty && cts_ok) state_d = S_READ;
      S_READ:     state_d = S_FETCH;
      S_FETCH: begin
        tx_data_d = fifo_dout;
        state_d   = S_START;
      end
      S_START:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (tx_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      // Counter was preloaded with GAP_CYCLES-1, so the state spans GAP_CYCLES clocks.
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each lands in the cycle its state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      start_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
      rd_en_q     <= (state_d == S_READ);
      start_q     <= (state_d == S_START);
      active_q    <= (state_d != S_IDLE);
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx_start   = start_q;
  assign tx_data    = tx_data_q;
  assign active     = active_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (GAP_CYCLES 0 and 4), each with a FIFO
// and transmitter model plus an event-timestamp reference model checked every cycle.
module tb_uart_tx_sched;

  localparam int BUSY_LEN = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic cts_n = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  int         ack_dly [2] = '{1, 1};
  logic [7:0] fq      [2][$];
  logic [7:0] sb      [2][$];
  int         rd_cnt  [2] = '{0, 0};
  int         start_cyc [2][$];
  logic [7:0] start_dat [2][$];
  int         comp_cyc  [2][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int GAP = (g == 0) ? 0 : 4;

    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout  = 8'h00;
    logic       rd_en, tx_start, active;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic [15:0] frame_cnt;
    int         tt;

    uart_tx_sched #(.DATA_WIDTH(8), .GAP_CYCLES(GAP), .CNT_WIDTH(16)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (rd_en),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .active     (active),
      .frame_cnt  (frame_cnt)
`ifdef UART_TX_SCHED_CTS_EN
      , .cts_n    (cts_n)
`endif
    );

    // FIFO: data appears the cycle after rd_en; contents survive DUT reset.
    always @(posedge clk) begin
      if (rd_en && fq[g].size() > 0) fifo_dout <= fq[g].pop_front();
      fifo_empty <= (fq[g].size() == 0);
    end

    // Transmitter: busy rises ack_dly cycles after tx_start and lasts BUSY_LEN cycles.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tt      <= 0;
        tx_busy <= 1'b0;
      end else begin
        tt      <= tx_start ? 1 : ((tt != 0 && tt < 64) ? tt + 1 : 0);
        tx_busy <= tx_start ? (ack_dly[g] == 1)
                            : (tt != 0 && tt + 1 >= ack_dly[g] && tt + 1 < ack_dly[g] + BUSY_LEN);
      end
    end

    // Reference model: a read follows an idle cycle with en & data; start is two
    // cycles after the read; a frame ends on the first low busy after it went high.
    initial begin
      int start_at, gap_left, exp_cnt;
      bit in_frame, seen, idle_p, en_p, empty_p, cts_p, exp_rd, act_exp;
      logic [7:0] held, exp_dat;
      start_at = -100; gap_left = 0; exp_cnt = 0; in_frame = 0; seen = 0;
      idle_p = 1; en_p = 0; empty_p = 1; cts_p = 1; held = 8'h00; exp_dat = 8'h00;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk("rst_rd_en", {31'b0, rd_en}, 0);
          chk("rst_tx_start", {31'b0, tx_start}, 0);
          chk("rst_active", {31'b0, active}, 0);
          chk("rst_frame_cnt", {16'b0, frame_cnt}, 0);
          chk("rst_tx_data", {24'b0, tx_data}, 0);
          start_at = -100; gap_left = 0; exp_cnt = 0; in_frame = 0; seen = 0;
          idle_p = 1; en_p = 0; empty_p = 1; cts_p = 1; held = 8'h00;
        end else begin
          exp_rd = idle_p && en_p && !empty_p && !cts_p;
          if (exp_rd) begin
            in_frame = 1;
            seen     = 0;
            start_at = cyc + 2;
            exp_dat  = (sb[g].size() > 0) ? sb[g].pop_front() : 8'hxx;
          end
          act_exp = in_frame || gap_left > 0;
          if (cyc == start_at) held = exp_dat;
          chk("rd_en", {31'b0, rd_en}, {31'b0, exp_rd});
          chk("tx_start", {31'b0, tx_start}, {31'b0, cyc == start_at});
          chk("tx_data", {24'b0, tx_data}, {24'b0, held});
          chk("active", {31'b0, active}, {31'b0, act_exp});
          chk("frame_cnt", {16'b0, frame_cnt}, exp_cnt);
          if (rd_en) rd_cnt[g]++;
          if (tx_start) begin
            start_cyc[g].push_back(cyc);
            start_dat[g].push_back(tx_data);
          end
          if (gap_left > 0) gap_left--;
          if (in_frame && cyc > start_at) begin
            if (tx_busy) seen = 1;
            else if (seen) begin
              exp_cnt  = (exp_cnt + 1) % 65536;
              in_frame = 0;
              seen     = 0;
              gap_left = GAP;
              comp_cyc[g].push_back(cyc);
            end
          end
          idle_p  = !act_exp;
          en_p    = en;
          empty_p = fifo_empty;
`ifdef UART_TX_SCHED_CTS_EN
          cts_p   = cts_n;
`else
          cts_p   = 1'b0;
`endif
        end
      end
    end
  end

  function automatic int frame_of(input int i);
    return (i == 0) ? int'(h[0].frame_cnt) : int'(h[1].frame_cnt);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fq[i].push_back(b);
    sb[i].push_back(b);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i] = 0;
      start_cyc[i].delete();
      start_dat[i].delete();
      comp_cyc[i].delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_frames(input string nm, input int i, input int n, input int budget);
    int k = 0;
    while (frame_of(i) < n && k < budget) begin
      step(1);
      k++;
    end
    chk(nm, frame_of(i), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2v [3];
    int k;
    t2v[0] = 8'hAA; t2v[1] = 8'hBB; t2v[2] = 8'hCC;

    step(3);
    rst_n = 1'b1;

    // Empty FIFO with en high: nothing moves.
    en = 1'b1;
    step(20);
    chk("t1_rd_cnt", rd_cnt[0] + rd_cnt[1], 0);
    chk("t1_starts", start_cyc[0].size() + start_cyc[1].size(), 0);
    chk("t1_active", {31'b0, h[0].active}, 0);
    chk("t1_frame_cnt", {16'b0, h[0].frame_cnt}, 0);

    // Three bytes, no gap.
    push(0, 8'hAA); push(0, 8'hBB); push(0, 8'hCC);
    wait_frames("t2_frames", 0, 3, 200);
    step(2);
    chk("t2_rd_cnt", rd_cnt[0], 3);
    chk("t2_nstarts", start_dat[0].size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < start_dat[0].size()) chk("t2_byte", {24'b0, start_dat[0][i]}, {24'b0, t2v[i]});
    chk("t2_fifo_empty", {31'b0, h[0].fifo_empty}, 1);
    chk("t2_active", {31'b0, h[0].active}, 0);

    // Back-to-back latency, gap 0 vs gap 4.
    clear_logs();
    push(0, 8'h11); push(0, 8'h22); push(1, 8'h33); push(1, 8'h44);
    wait_frames("t3_frames_g0", 0, 5, 200);
    wait_frames("t3_frames_g4", 1, 2, 200);
    step(8);
    if (start_cyc[0].size() == 2 && comp_cyc[0].size() > 0)
      chk("t3_latency_gap0", start_cyc[0][1] - comp_cyc[0][0], 4);
    else chk("t3_logs_gap0", start_cyc[0].size(), 2);
    if (start_cyc[1].size() == 2 && comp_cyc[1].size() > 0)
      chk("t3_latency_gap4", start_cyc[1][1] - comp_cyc[1][0], 8);
    else chk("t3_logs_gap4", start_cyc[1].size(), 2);

    // Drop en mid-frame: current frame finishes, then park.
    do_reset();
    clear_logs();
    push(0, 8'h31); push(0, 8'h32); push(0, 8'h33);
    k = 0;
    while (!h[0].tx_busy && k < 50) begin step(1); k++; end
    chk("t4_busy_seen", {31'b0, h[0].tx_busy}, 1);
    step(2);
    en = 1'b0;
    step(40);
    chk("t4_rd_cnt", rd_cnt[0], 1);
    chk("t4_fifo_empty", {31'b0, h[0].fifo_empty}, 0);
    chk("t4_frame_cnt", {16'b0, h[0].frame_cnt}, 1);
    chk("t4_active", {31'b0, h[0].active}, 0);
    en = 1'b1;
    wait_frames("t4_frames", 0, 3, 200);
    step(2);
    chk("t4_rd_total", rd_cnt[0], 3);
    if (start_dat[0].size() == 3) begin
      chk("t4_byte2", {24'b0, start_dat[0][1]}, 32'h32);
      chk("t4_byte3", {24'b0, start_dat[0][2]}, 32'h33);
    end else chk("t4_nstarts", start_dat[0].size(), 3);

    // Async reset while waiting for the transmitter to acknowledge.
    clear_logs();
    ack_dly[0] = 6;
    push(0, 8'h55); push(0, 8'h66);
    k = 0;
    while (!h[0].tx_start && k < 50) begin step(1); k++; end
    chk("t5_start_seen", {31'b0, h[0].tx_start}, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_start", {31'b0, h[0].tx_start}, 0);
    chk("t5_rst_rd_en", {31'b0, h[0].rd_en}, 0);
    chk("t5_rst_active", {31'b0, h[0].active}, 0);
    chk("t5_rst_frame_cnt", {16'b0, h[0].frame_cnt}, 0);
    chk("t5_rst_tx_data", {24'b0, h[0].tx_data}, 0);
    step(2);
    rst_n = 1'b1;
    k = 0;
    do begin step(1); k++; end while (!h[0].rd_en && k < 6);
    chk("t5_fresh_read", {31'b0, h[0].rd_en}, 1);
    wait_frames("t5_frames", 0, 1, 200);
    step(2);
    if (start_dat[0].size() > 0)
      chk("t5_byte", {24'b0, start_dat[0][start_dat[0].size() - 1]}, 32'h66);
    else chk("t5_nstarts", start_dat[0].size(), 2);
    ack_dly[0] = 1;

`ifdef UART_TX_SCHED_CTS_EN
    // Clear-to-send gating of the idle exit.
    do_reset();
    clear_logs();
    cts_n = 1'b1;
    push(0, 8'hDD);
    step(30);
    chk("t6_rd_blocked", rd_cnt[0], 0);
    cts_n = 1'b0;
    k = 0;
    do begin step(1); k++; end while (!h[0].rd_en && k < 10);
    chk("t6_rd_latency", k, 1);
    wait_frames("t6_frames", 0, 1, 200);
    if (start_dat[0].size() > 0) chk("t6_byte", {24'b0, start_dat[0][0]}, 32'hDD);
    else chk("t6_nstarts", start_dat[0].size(), 1);
`endif

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit-side scheduler between the UART TX FIFO and the UART transmitter engine. It drains the FIFO one byte at a time, loads each byte into the transmitter with a start pulse, and waits for that frame to finish. It then inserts an optional inter-frame idle gap before fetching the next byte. It is the only agent that asserts the TX FIFO's rd_en.

Parameters:
DATA_WIDTH, 8, width of FIFO data and transmitter data
GAP_CYCLES, 0, idle clocks inserted after each frame completes (0..255; 0 = no GAP state)
CNT_WIDTH, 16, width of the transmitted-frame counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scheduler enable; level-sensitive
fifo_empty  input  1  TX FIFO empty flag
fifo_dout  input  DATA_WIDTH  TX FIFO read data; valid the cycle after rd_en
fifo_rd_en  output  1  TX FIFO read strobe, registered, one-cycle pulse
tx_busy  input  1  transmitter busy; high for the duration of a frame
tx_start  output  1  transmitter load strobe, registered, one-cycle pulse
tx_data  output  DATA_WIDTH  byte presented to the transmitter; held stable
active  output  1  high whenever the state is not IDLE
frame_cnt  output  CNT_WIDTH  frames completed since reset; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async assert, sync-deasserted externally): state=IDLE. fifo_rd_en=0, tx_start=0, tx_data=0, active=0, frame_cnt=0, gap counter=0. Any frame in flight is abandoned; its byte is lost.
- All outputs are registered (Moore decode of state). No combinational path exists from inputs to outputs.
- States: IDLE, READ, FETCH, START, WAIT_ACK, WAIT_DONE, GAP.
- IDLE -> READ when en=1 and fifo_empty=0; otherwise stay in IDLE.
- READ: fifo_rd_en=1 for exactly this cycle. Next state is FETCH unconditionally.
- FETCH: capture fifo_dout into tx_data at the end of the cycle. Next state is START.
- START: tx_start=1 for exactly one cycle. Next state is WAIT_ACK.
- WAIT_ACK: remain until tx_busy=1, then go to WAIT_DONE. No timeout.
- WAIT_DONE: remain while tx_busy=1. On the first cycle with tx_busy=0:
  - frame_cnt increments.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: load the counter with GAP_CYCLES-1 on entry. Decrement each cycle; go to IDLE when the counter reaches 0. The state lasts exactly GAP_CYCLES cycles.
- Latency: first cycle tx_busy is sampled low -> next tx_start is GAP_CYCLES+4 clocks later, if the FIFO is non-empty and en=1.
- First byte: en=1 and a non-empty FIFO seen in IDLE at cycle t -> rd_en in t+1, tx_start in t+3.
- fifo_rd_en is never asserted while fifo_empty=1 is sampled in IDLE. The scheduler never underflows the FIFO.
- Clearing en is honoured only in IDLE. A frame already past IDLE runs to completion, including GAP, and the block then parks in IDLE.
- tx_data holds its last loaded value in all states until the next FETCH.
- fifo_empty changing after READ has no effect. The FIFO already guaranteed one valid word.

Optional Feature:
Macro UART_TX_SCHED_CTS_EN.
- Defined: adds input port cts_n (1 bit, active-low clear-to-send; synchronised externally). The IDLE -> READ transition additionally requires cts_n=0. cts_n has no effect once the scheduler has left IDLE.
- Undefined: no cts_n port; behaviour is exactly as above.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (3-bit, IDLE=0).
  - default DATA_WIDTH=8.
  - GAP counter width (8).
- No sub-module is natural. The FSM, gap counter and frame counter stay in one module. The FIFO and transmitter are instantiated by the parent.

Test Plan:
1. Reset, FIFO empty, en=1 for 20 cycles -> fifo_rd_en and tx_start never assert; active=0; frame_cnt=0.
2. Write 8'hAA, 8'hBB, 8'hCC to the FIFO. Transmitter model raises tx_busy 1 cycle after tx_start and holds it 10 cycles. Required: three tx_start pulses with tx_data AA, BB, CC in order; exactly three rd_en pulses; frame_cnt=3; FIFO empty; active returns to 0.
3. GAP_CYCLES=4 with two bytes queued -> second tx_start occurs exactly 8 clocks after tx_busy is first sampled low. With GAP_CYCLES=0 it occurs exactly 4 clocks after.
4. Queue 3 bytes and drop en during the first frame's WAIT_DONE -> first frame completes, no further rd_en, fifo_empty=0, frame_cnt=1. Re-raise en -> remaining 2 bytes are sent.
5. Assert rst_n=0 mid-cycle during WAIT_ACK -> tx_start, fifo_rd_en, active and frame_cnt go to 0 immediately, before the next edge. After release with FIFO non-empty, a fresh READ occurs.
6. With UART_TX_SCHED_CTS_EN and cts_n=1, byte 8'hDD queued for 30 cycles -> no rd_en. cts_n=0 -> rd_en 1 cycle later; tx_data=8'hDD at tx_start.
